instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch controller that sequences the instruction memory for the core.
- Holds the PC and issues word reads, honouring the memory's stall signal.
- Buffers returned words with their PCs in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects, including a redirect that lands while a read is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, prefetch entries (power of 2, >=2)
ADDR_W, 32, address/PC width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ADDR_W  word-aligned read address to instruction memory
imem_req  out  1  read request
imem_rdata  in  32  read data; valid in the completion cycle
imem_stall  in  1  memory busy; the current request has not completed
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  ADDR_W  redirect target
inst_valid  out  1  FIFO head valid
inst_data  out  32  instruction at FIFO head
inst_pc  out  ADDR_W  PC of FIFO head
inst_ready  in  1  decode accepts head
fetch_fault  out  1  misaligned redirect; fetch halted
fault_pc  out  ADDR_W  offending redirect target

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All flops clear asynchronously.
- Reset values:
  - pc=imem_addr=RESET_PC; imem_req=0; FIFO count=0; inst_valid=0; inst_data=0; inst_pc=0.
  - fetch_fault=0; fault_pc=0; discard=0; state=S_IDLE.
- Completion: a cycle with imem_req=1 and imem_stall=0. imem_rdata belongs to imem_addr in that cycle.
- While imem_req=1 and imem_stall=1, imem_addr and imem_req hold stable.
- FSM states:
  - S_IDLE: the first clock after reset release goes to S_FETCH. No request is issued in S_IDLE.
  - S_FETCH: imem_req=1.
    - Completion with discard=0: push {pc, rdata}; pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0).
    - If the push makes count==FIFO_DEPTH with no pop in the same cycle, go to S_FULL.
    - Stall: go to S_STALL.
  - S_STALL: imem_req=1, address held. Completion returns to S_FETCH (or S_FULL), with the same push rules.
  - S_FULL: imem_req=0. Any pop goes to S_FETCH; the request re-issues the next cycle.
  - S_FAULT: imem_req=0, fetch_fault=1. Exit only on an aligned redirect.
- Pop: inst_valid && inst_ready. A push and a pop in the same cycle leave count unchanged. inst_* stay stable while valid and not ready.
- inst_valid is registered and reflects count!=0. Data reaches inst_valid one cycle after completion (fetch latency of 1 cycle with no stall).
- Redirect (highest priority; overrides push and pop in the same cycle):
  - FIFO flushes; inst_valid=0 the next cycle; pc<=redirect_pc.
  - If the redirect arrives without a stall (including a completion cycle): that completion's data is dropped. Next state is S_FETCH and the new address is driven the next cycle.
  - If imem_req=1 and imem_stall=1 in the redirect cycle: set discard=1 and stay in S_STALL with the old address held.
    - On completion, drop the data and clear discard.
    - The next cycle requests redirect_pc.
  - A second redirect while discard=1 only updates pc.
  - redirect_pc[1:0]!=0: flush; fault_pc<=redirect_pc; go to S_FAULT (after any pending stalled read completes and is discarded).
  - An aligned redirect in S_FAULT clears fetch_fault and goes to S_FETCH.
- Reset asserted mid-stall: all state clears immediately. The memory must tolerate request withdrawal on reset.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_IDLE, S_FETCH, S_STALL, S_FULL, S_FAULT}.
  - INSTR_BYTES=4.
  - fetch_entry_t struct {pc, data}.
- Sub-module fetch_fifo: synchronous FIFO_DEPTH-entry FIFO of fetch_entry_t with push/pop/flush, count, and registered head outputs.

Test Plan:
- Reset release, imem_stall=0, inst_ready=1, memory returns addr^32'hA5A5_0000 -> requests 0,4,8,... on consecutive cycles. inst_valid rises 2 cycles after rst_n rises. inst_pc/inst_data pairs match.
- inst_ready=0 -> exactly 2 entries (PC 0,4) buffered; imem_req drops with imem_addr=8. Raising inst_ready re-requests 8 the cycle after the first pop.
- imem_stall high for 3 cycles on addr 0x104 -> imem_addr held at 0x104 all 3 cycles. Entry 0x104 delivered once; next request 0x108.
- Redirect to 0x200 during a stall on 0x10 -> 0x10 held until the stall ends and its data is dropped. The next request is 0x200 and the first inst_pc is 0x200.
- Redirect to 0x203 -> fetch_fault=1, fault_pc=0x203, no imem_req. Redirect to 0x300 -> fault clears; fetch resumes at 0x300.
- Redirect to 32'hFFFF_FFFC -> the next request wraps to 0x0. Redirect plus pop in the same cycle -> FIFO empty next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int PC_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STALL, S_FULL, S_FAULT} fetch_state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {pc, data} with flush and registered head outputs
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [AW:0] count_pop, count_nx;
  logic do_push, do_pop;
  always_comb begin
    do_pop    = pop && count != '0 && !flush;
    do_push   = push && !flush && (count != (AW+1)'(DEPTH) || do_pop);
    rd_ptr_nx = rd_ptr + AW'(do_pop);
    count_pop = count - (AW+1)'(do_pop);
    count_nx  = count_pop + (AW+1)'(do_push);
  end
  // the head is refreshed on the same edge as the push, giving one-cycle fetch latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_ptr_nx;
      count      <= count_nx;
      head_valid <= count_nx != '0;
      if (count_nx != '0) head <= count_pop == '0 ? wr_entry : mem[rd_ptr_nx];
    end
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencing, stall-aware memory requests, prefetch buffering and redirects
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_fault,
  output logic [ADDR_W-1:0] fault_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, hold_addr, hold_nx, fault_pc_nx;
  logic discard, discard_nx, fault_pend, fault_pend_nx;
  logic push, flush, pop, misalign, full_after;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign imem_req    = state == S_FETCH || state == S_STALL;
  assign imem_addr   = discard ? hold_addr : pc;
  assign fetch_fault = state == S_FAULT;
  assign pop         = inst_valid && inst_ready;
  assign misalign    = redirect_pc[1:0] != 2'b00;
  assign full_after  = count == CW'(FIFO_DEPTH - 1) && !pop;
  assign inst_data   = head.data;
  assign inst_pc     = ADDR_W'(head.pc);
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    hold_nx       = hold_addr;
    discard_nx    = discard;
    fault_pend_nx = fault_pend;
    fault_pc_nx   = fault_pc;
    push          = 1'b0;
    flush         = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (misalign) fault_pc_nx = redirect_pc;
      else pc_nx = redirect_pc;
      // a stalled read cannot be withdrawn: keep presenting it and drop its data later
      if (imem_req && imem_stall) begin
        hold_nx       = discard ? hold_addr : pc;
        discard_nx    = 1'b1;
        fault_pend_nx = misalign;
        state_nx      = S_STALL;
      end else begin
        discard_nx    = 1'b0;
        fault_pend_nx = 1'b0;
        state_nx      = misalign ? S_FAULT : S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: state_nx = S_FETCH;
        S_FETCH, S_STALL: begin
          if (imem_stall) state_nx = S_STALL;
          else if (discard) begin
            discard_nx    = 1'b0;
            fault_pend_nx = 1'b0;
            state_nx      = fault_pend ? S_FAULT : S_FETCH;
          end else begin
            push     = 1'b1;
            pc_nx    = pc + ADDR_W'(INSTR_BYTES);
            state_nx = full_after ? S_FULL : S_FETCH;
          end
        end
        S_FULL:  state_nx = pop ? S_FETCH : S_FULL;
        default: state_nx = state;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= ADDR_W'(RESET_PC);
      hold_addr  <= '0;
      discard    <= 1'b0;
      fault_pend <= 1'b0;
      fault_pc   <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      hold_addr  <= hold_nx;
      discard    <= discard_nx;
      fault_pend <= fault_pend_nx;
      fault_pc   <= fault_pc_nx;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_entry  ('{pc: PC_W'(pc), data: imem_rdata}),
    .count     (count),
    .head_valid(inst_valid),
    .head      (head)
  );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: table-driven per-cycle checks plus hand sequences for stalled redirects and reset
module tb_instr_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_data, inst_pc, fault_pc;
  logic imem_req, imem_stall, redirect_valid, inst_valid, inst_ready, fetch_fault;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {
    logic st, rdy, rv;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic v;
    logic [31:0] ipc;
    logic flt;
  } vec_t;
  vec_t tbl [25];
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_stall(imem_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic vec_t mk(input logic st, rdy, rv, input logic [31:0] rpc, input logic req,
                              input logic [31:0] addr, input logic v, input logic [31:0] ipc,
                              input logic flt);
    vec_t r;
    r.st = st; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.req = req;
    r.addr = addr; r.v = v; r.ipc = ipc; r.flt = flt;
    return r;
  endfunction
  task automatic drive(input logic st, rdy, rv, input logic [31:0] rpc);
    imem_stall = st; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
  endtask
  initial begin
    tbl[0]  = mk(0, 1, 0, 0,            1, 32'h0,        0, 0,            0);
    tbl[1]  = mk(0, 1, 0, 0,            1, 32'h4,        1, 32'h0,        0);
    tbl[2]  = mk(0, 0, 0, 0,            1, 32'h8,        1, 32'h4,        0);
    tbl[3]  = mk(0, 0, 0, 0,            0, 32'hC,        1, 32'h4,        0);
    tbl[4]  = mk(0, 1, 0, 0,            0, 32'hC,        1, 32'h4,        0);
    tbl[5]  = mk(0, 1, 0, 0,            1, 32'hC,        1, 32'h8,        0);
    tbl[6]  = mk(1, 1, 0, 0,            1, 32'h10,       1, 32'hC,        0);
    tbl[7]  = mk(1, 1, 0, 0,            1, 32'h10,       0, 0,            0);
    tbl[8]  = mk(1, 1, 0, 0,            1, 32'h10,       0, 0,            0);
    tbl[9]  = mk(0, 1, 0, 0,            1, 32'h10,       0, 0,            0);
    tbl[10] = mk(0, 1, 0, 0,            1, 32'h14,       1, 32'h10,       0);
    tbl[11] = mk(1, 1, 1, 32'h200,      1, 32'h18,       1, 32'h14,       0);
    tbl[12] = mk(1, 1, 0, 0,            1, 32'h18,       0, 0,            0);
    tbl[13] = mk(0, 1, 0, 0,            1, 32'h18,       0, 0,            0);
    tbl[14] = mk(0, 1, 0, 0,            1, 32'h200,      0, 0,            0);
    tbl[15] = mk(0, 1, 1, 32'h203,      1, 32'h204,      1, 32'h200,      0);
    tbl[16] = mk(0, 1, 0, 0,            0, 32'h204,      0, 0,            1);
    tbl[17] = mk(0, 1, 1, 32'h300,      0, 32'h204,      0, 0,            1);
    tbl[18] = mk(0, 1, 0, 0,            1, 32'h300,      0, 0,            0);
    tbl[19] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, 32'h304,     1, 32'h300,      0);
    tbl[20] = mk(0, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,           0);
    tbl[21] = mk(0, 0, 0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC, 0);
    tbl[22] = mk(0, 1, 1, 32'h40,       0, 32'h4,        1, 32'hFFFF_FFFC, 0);
    tbl[23] = mk(0, 1, 0, 0,            1, 32'h40,       0, 0,            0);
    tbl[24] = mk(1, 1, 0, 0,            1, 32'h44,       1, 32'h40,       0);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_data", inst_data, 0);
    chk("rst_ipc", inst_pc, 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_fault_pc", fault_pc, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].flt));
      if (tbl[i].v) begin
        chk($sformatf("row%0d_ipc", i), inst_pc, tbl[i].ipc);
        chk($sformatf("row%0d_data", i), inst_data, tbl[i].ipc ^ 32'hA5A5_0000);
      end
      drive(tbl[i].st, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
    end
    @(negedge clk);
    chk("stall44_req", 32'(imem_req), 1);
    chk("stall44_addr", imem_addr, 32'h44);
    chk("stall44_valid", 32'(inst_valid), 0);
    drive(1, 1, 1, 32'h123);
    @(negedge clk);
    chk("misred_hold_addr", imem_addr, 32'h44);
    chk("misred_hold_req", 32'(imem_req), 1);
    chk("misred_no_fault_yet", 32'(fetch_fault), 0);
    drive(0, 1, 0, 0);
    @(negedge clk);
    chk("misred_fault", 32'(fetch_fault), 1);
    chk("misred_fault_pc", fault_pc, 32'h123);
    chk("misred_req", 32'(imem_req), 0);
    chk("misred_valid", 32'(inst_valid), 0);
    drive(0, 1, 1, 32'h500);
    @(negedge clk);
    chk("recover_req", 32'(imem_req), 1);
    chk("recover_addr", imem_addr, 32'h500);
    chk("recover_fault", 32'(fetch_fault), 0);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst_stall_addr", imem_addr, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_valid", 32'(inst_valid), 0);
    chk("async_rst_fault_pc", fault_pc, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
